// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing and shared types for the VGA sync generator.
package vga_timing_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int DEF_CNT_W     = 10;
  typedef logic [DEF_CNT_W-1:0] coord_t;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; wrapping position counter with registered visible/sync decode.
module vga_axis_counter #(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             visible,
  output logic             sync_active
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS    = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] S_FROM = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] S_TO   = CNT_W'(VISIBLE + FRONT + SYNC);
  logic [CNT_W-1:0] nxt;
  assign wrap = count == LAST;
  assign nxt  = wrap ? '0 : count + 1'b1;
  // decode the next position so flags land on the same edge as the count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count       <= LAST;
      visible     <= 1'b0;
      sync_active <= 1'b0;
    end else if (enable) begin
      count       <= nxt;
      visible     <= nxt < VIS;
      sync_active <= nxt >= S_FROM && nxt < S_TO;
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing driven by a pixel_tick enable, all in the clk domain.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int SYNC_POL  = 0,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);
  localparam logic POL = SYNC_POL != 0;
  logic [1:0] rst_sync;
  logic run, adv, h_wrap, v_wrap, h_vis, v_vis, h_act, v_act;
  sync_t sync;
  // reset asserts asynchronously but only lets the raster move two clks after release
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign run = rst_sync[1];
  assign adv = pixel_tick && run;
  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .reset(reset), .enable(adv),
    .count(pixel_x), .wrap(h_wrap), .visible(h_vis), .sync_active(h_act)
  );
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .reset(reset), .enable(adv && h_wrap),
    .count(pixel_y), .wrap(v_wrap), .visible(v_vis), .sync_active(v_act)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= adv && h_wrap;
      frame_start <= adv && h_wrap && v_wrap;
    end
  always_comb begin
    sync.hsync    = POL ? h_act : !h_act;
    sync.vsync    = POL ? v_act : !v_act;
    sync.video_on = h_vis && v_vis;
  end
  assign hsync    = sync.hsync;
  assign vsync    = sync.vsync;
  assign video_on = sync.video_on;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized pixel_tick stimulus against a linear-index raster model, two geometries.
module tb_vga_sync_gen;
  logic clk = 1'b0, reset = 1'b0, pixel_tick = 1'b0;
  logic hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [3:0] s_pixel_x, s_pixel_y;
  int vectors = 0, miscompares = 0;
  longint n = 0;
  bit adv = 1'b0;

  vga_sync_gen dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CNT_W(4)
  ) dut_s (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // position after n advances from reset is linear index (n-1) mod frame size
  task automatic check_axis(input string tag, input int hv, hf, hs, hb, vv, vf, vs, vb,
                            input logic [9:0] x, y, input logic h, v, von, ls, fs);
    int ht, vt, tot, p, ex, ey;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    tot = ht * vt;
    p = int'(((n % longint'(tot)) + longint'(tot) - 1) % longint'(tot));
    ex = p % ht;
    ey = p / ht;
    chk({tag, ".x"}, 32'(x), ex);
    chk({tag, ".y"}, 32'(y), ey);
    chk({tag, ".hsync"}, 32'(h), 32'(!(ex >= hv + hf && ex < hv + hf + hs)));
    chk({tag, ".vsync"}, 32'(v), 32'(!(ey >= vv + vf && ey < vv + vf + vs)));
    chk({tag, ".video_on"}, 32'(von), 32'(ex < hv && ey < vv));
    chk({tag, ".line_start"}, 32'(ls), 32'(adv && ex == 0));
    chk({tag, ".frame_start"}, 32'(fs), 32'(adv && ex == 0 && ey == 0));
  endtask

  task automatic check_all();
    vectors++;
    check_axis("big", 640, 16, 96, 48, 480, 10, 2, 33, pixel_x, pixel_y,
               hsync, vsync, video_on, line_start, frame_start);
    check_axis("small", 8, 2, 2, 2, 4, 1, 1, 1, 10'(s_pixel_x), 10'(s_pixel_y),
               s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start);
  endtask

  task automatic cyc(input bit t);
    pixel_tick = t;
    @(posedge clk);
    adv = t && reset;
    if (adv) n++;
    #1;
    check_all();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    repeat (3) cyc(1'b0);
  endtask

  initial begin
    int hs_cnt, ls_cnt, fs_cnt, guard;
    longint n0;
    reset = 1'b0;
    repeat (3) cyc(1'b1);
    release_reset();
    cyc(1'b1);
    chk("first_frame_start", 32'(frame_start), 1);
    chk("first_xy", {pixel_x, 6'd0, pixel_y}, 0);
    hs_cnt = 0;
    ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      cyc(1'b1);
      if (hsync === 1'b0) hs_cnt++;
      if (line_start === 1'b1) ls_cnt++;
      repeat (3) cyc(1'b0);
    end
    chk("hsync_ticks_per_line", hs_cnt, 96);
    chk("line_starts_per_line", ls_cnt, 1);
    n0 = n;
    fs_cnt = 0;
    for (int i = 0; i < 14000; i++) begin
      cyc(1'b1);
      if (s_frame_start === 1'b1) fs_cnt++;
    end
    chk("small_frame_count", fs_cnt, int'((n - 1) / 98 - (n0 - 1) / 98));
    repeat (50) cyc(1'b0);
    for (int i = 0; i < 20000; i++) cyc($urandom_range(0, 3) == 0);
    for (int i = 0; i < 4000; i++) cyc($urandom_range(0, 1) == 1);
    guard = 0;
    while ((n - 1) % 800 != 700 && guard < 1000) begin
      cyc(1'b1);
      guard++;
    end
    chk("reach_x700", 32'(pixel_x), 700);
    chk("hsync_active_at_700", 32'(hsync), 0);
    #2 reset = 1'b0;
    pixel_tick = 1'b1;
    n = 0;
    adv = 1'b0;
    #1 check_all();
    repeat (3) cyc(1'b1);
    release_reset();
    cyc(1'b1);
    chk("post_reset_frame_start", 32'(frame_start), 1);
    for (int i = 0; i < 300; i++) cyc($urandom_range(0, 2) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
